// File: rtl/branch_unit_ras_pkg.sv
// Shared definitions for the branch unit: branch opcode constants, flag bit
// positions and a helper that classifies a 6-bit bcode into a branch kind.
package branch_unit_ras_pkg;

    // Opcode fields. Conditional and JR codes are matched on bcode[5:3] only.
    localparam logic [2:0] BC_COND = 3'b011;
    localparam logic [5:0] BC_CALL = 6'b100000;
    localparam logic [5:0] BC_JMP  = 6'b100001;
    localparam logic [5:0] BC_RET  = 6'b100010;
    localparam logic [5:0] BC_RSVD = 6'b100011;
    localparam logic [2:0] BC_JR   = 3'b101;

    // Bit positions inside the {ovf, sign, carry, zero} flag vector.
    localparam int FLG_Z = 0;
    localparam int FLG_C = 1;
    localparam int FLG_S = 2;
    localparam int FLG_V = 3;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_COND,
        OP_CALL,
        OP_JMP,
        OP_RET,
        OP_JR
    } br_op_e;

    // The reserved pattern 10x1xx overlaps the upper half of the JR space
    // (1011xx). Reserved wins, so JR is effectively 1010xx.
    function automatic br_op_e decode_op(input logic [5:0] bc);
        br_op_e op;
        op = OP_NONE;
        if (bc[5:3] == BC_COND) begin
            op = OP_COND;
        end else if (bc == BC_CALL) begin
            op = OP_CALL;
        end else if (bc == BC_JMP) begin
            op = OP_JMP;
        end else if (bc == BC_RET) begin
            op = OP_RET;
        end else if ((bc == BC_RSVD) || ((bc[5:4] == 2'b10) && bc[2])) begin
            op = OP_NONE;
        end else if (bc[5:3] == BC_JR) begin
            op = OP_JR;
        end
        return op;
    endfunction

endpackage

// File: rtl/branch_unit_ras_ras_stack.sv
// Return-address stack: circular buffer indexed by a top pointer that marks
// the next free slot. A push while full overwrites the oldest entry (the
// pointer simply wraps) and the count saturates. A pop while empty is ignored.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   push         write push_data at the top
//   push_data    return address to save
//   pop          remove the top entry (ignored when empty)
//   pop_data     current top entry (meaningful when !empty)
//   count        occupancy, 0..RAS_DEPTH
//   full, empty  occupancy status
module ras_stack #(
    parameter int PC_W      = 11,
    parameter int RAS_DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [PC_W-1:0]              push_data,
    input  logic                         pop,
    output logic [PC_W-1:0]              pop_data,
    output logic [$clog2(RAS_DEPTH):0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_W-1:0]  mem_q [RAS_DEPTH];
    logic [PC_W-1:0]  mem_d [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] top_idx;

    assign top_idx  = ptr_q - PTR_W'(1);
    assign pop_data = mem_q[top_idx];
    assign full     = (count_q == CNT_W'(RAS_DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

    // Pointer arithmetic wraps naturally because RAS_DEPTH is a power of two.
    always_comb begin
        mem_d   = mem_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PTR_W'(1);
            if (!full) begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop && !empty) begin
            ptr_d   = top_idx;
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/branch_unit_ras.sv
// Branch-resolution unit with a return-address stack. Resolves conditional,
// unconditional, call/return and register-indirect branches and presents a
// registered one-cycle taken pulse plus target PC to fetch.
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   br_valid, bcode  branch request and opcode
//   lit, rega        literal and register targets (low PC_W bits used)
//   pc_cur           PC of the branch (CALL pushes pc_cur+1)
//   flag_we/flags_in flag register load, {ovf, sign, carry, zero}
//   err_clr          clear sticky RAS error bits
//   br_taken/target  registered redirect pulse and address
//   ras_count        stack occupancy
//   ras_ovf/ras_unf  sticky push-while-full / pop-while-empty
module branch_unit_ras
    import branch_unit_ras_pkg::*;
#(
    parameter int PC_W      = 11,
    parameter int DATA_W    = 32,
    parameter int RAS_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        br_valid,
    input  logic [5:0]                  bcode,
    input  logic [DATA_W-1:0]           lit,
    input  logic [DATA_W-1:0]           rega,
    input  logic [PC_W-1:0]             pc_cur,
    input  logic                        flag_we,
    input  logic [3:0]                  flags_in,
    input  logic                        err_clr,
    output logic                        br_taken,
    output logic [PC_W-1:0]             br_target,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        ras_ovf,
    output logic                        ras_unf
);
    logic [3:0]      flags_q, flags_d;
    logic            br_taken_q, br_taken_d;
    logic [PC_W-1:0] br_target_q, br_target_d;
    logic            ras_ovf_q, ras_ovf_d;
    logic            ras_unf_q, ras_unf_d;

    logic [3:0]      eff_flags;
    br_op_e          op;
    logic            cond_true;
    logic            push, pop;
    logic [PC_W-1:0] pop_data;
    logic            full, empty;
    logic            unused_bits;

    assign unused_bits = ^{lit[DATA_W-1:PC_W], rega[DATA_W-1:PC_W]};

    // A flag write in the same cycle as a conditional branch is bypassed so
    // the branch sees the freshest ALU result.
    assign eff_flags = flag_we ? flags_in : flags_q;
    assign op        = decode_op(bcode);

    // ccc[2:1] picks the flag, ccc[0] inverts the test (odd codes test for 0).
    always_comb begin
        cond_true = 1'b0;
        case (bcode[2:1])
            2'd0:    cond_true = eff_flags[FLG_Z];
            2'd1:    cond_true = eff_flags[FLG_C];
            2'd2:    cond_true = eff_flags[FLG_S];
            default: cond_true = eff_flags[FLG_V];
        endcase
        cond_true = cond_true ^ bcode[0];
    end

    // Next-state decision. br_target holds unless a branch is taken; a RET
    // on an empty stack is not taken and leaves the target alone.
    always_comb begin
        br_taken_d  = 1'b0;
        br_target_d = br_target_q;
        push        = 1'b0;
        pop         = 1'b0;
        if (br_valid) begin
            case (op)
                OP_COND: begin
                    br_taken_d = cond_true;
                    if (cond_true) br_target_d = lit[PC_W-1:0];
                end
                OP_CALL: begin
                    br_taken_d  = 1'b1;
                    br_target_d = lit[PC_W-1:0];
                    push        = 1'b1;
                end
                OP_JMP: begin
                    br_taken_d  = 1'b1;
                    br_target_d = lit[PC_W-1:0];
                end
                OP_RET: begin
                    pop = 1'b1;
                    if (!empty) begin
                        br_taken_d  = 1'b1;
                        br_target_d = pop_data;
                    end
                end
                OP_JR: begin
                    br_taken_d  = 1'b1;
                    br_target_d = rega[PC_W-1:0];
                end
                default: ;
            endcase
        end
        flags_d   = flag_we ? flags_in : flags_q;
        ras_ovf_d = (ras_ovf_q & ~err_clr) | (push & full);
        ras_unf_d = (ras_unf_q & ~err_clr) | (pop & empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q     <= '0;
            br_taken_q  <= 1'b0;
            br_target_q <= '0;
            ras_ovf_q   <= 1'b0;
            ras_unf_q   <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            br_taken_q  <= br_taken_d;
            br_target_q <= br_target_d;
            ras_ovf_q   <= ras_ovf_d;
            ras_unf_q   <= ras_unf_d;
        end
    end

    ras_stack #(
        .PC_W      (PC_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (pc_cur + PC_W'(1)),
        .pop       (pop),
        .pop_data  (pop_data),
        .count     (ras_count),
        .full      (full),
        .empty     (empty)
    );

    assign br_taken  = br_taken_q;
    assign br_target = br_target_q;
    assign ras_ovf   = ras_ovf_q;
    assign ras_unf   = ras_unf_q;

endmodule

// File: tb/tb_branch_unit_ras.sv
// Bench for branch_unit_ras: directed scenarios followed by random traffic.
// Every stimulus cycle runs through a queue-based reference model whose
// expected response is queued; an independent monitor pops and compares.
module tb_branch_unit_ras;
    localparam int PC_W      = 11;
    localparam int DATA_W    = 32;
    localparam int RAS_DEPTH = 8;
    localparam int PC_MOD    = 1 << PC_W;

    logic              clk;
    logic              rst;
    logic              br_valid;
    logic [5:0]        bcode;
    logic [DATA_W-1:0] lit;
    logic [DATA_W-1:0] rega;
    logic [PC_W-1:0]   pc_cur;
    logic              flag_we;
    logic [3:0]        flags_in;
    logic              err_clr;
    logic              br_taken;
    logic [PC_W-1:0]   br_target;
    logic [3:0]        ras_count;
    logic              ras_ovf;
    logic              ras_unf;

    branch_unit_ras #(
        .PC_W      (PC_W),
        .DATA_W    (DATA_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .br_valid  (br_valid),
        .bcode     (bcode),
        .lit       (lit),
        .rega      (rega),
        .pc_cur    (pc_cur),
        .flag_we   (flag_we),
        .flags_in  (flags_in),
        .err_clr   (err_clr),
        .br_taken  (br_taken),
        .br_target (br_target),
        .ras_count (ras_count),
        .ras_ovf   (ras_ovf),
        .ras_unf   (ras_unf)
    );

    typedef struct {
        bit          rst;
        bit          br_valid;
        bit [5:0]    bcode;
        bit [31:0]   lit;
        bit [31:0]   rega;
        bit [10:0]   pc;
        bit          flag_we;
        bit [3:0]    flags;
        bit          err_clr;
    } stim_t;

    typedef struct {
        bit        taken;
        bit [10:0] target;
        int        count;
        bit        ovf;
        bit        unf;
        string     name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state, in plain terms: a list of return addresses
    // (newest at the back), the flag nibble, the last redirect and sticky bits.
    int        m_stk[$];
    bit [3:0]  m_flags = 0;
    bit [10:0] m_target = 0;
    bit        m_ovf = 0;
    bit        m_unf = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t br(input bit [5:0] bc, input int tgt, input int pc);
        stim_t s;
        s          = idle();
        s.br_valid = 1'b1;
        s.bcode    = bc;
        s.lit      = tgt;
        s.pc       = pc[10:0];
        return s;
    endfunction

    // Condition codes in the order Z=1, Z=0, C=1, C=0, S=1, S=0, V=1, V=0,
    // flags are {ovf, sign, carry, zero}.
    function automatic bit cond_holds(input int ccc, input bit [3:0] f);
        bit z, c, sg, v;
        z = f[0]; c = f[1]; sg = f[2]; v = f[3];
        case (ccc)
            0: return z;
            1: return !z;
            2: return c;
            3: return !c;
            4: return sg;
            5: return !sg;
            6: return v;
            default: return !v;
        endcase
    endfunction

    task automatic applyStimulus(input stim_t s, input string nm);
        exp_t e;
        bit   taken;
        int   tgt;
        bit   ovf_ev, unf_ev;
        bit [3:0] eff;
        int   op;
        @(negedge clk);
        rst      = s.rst;
        br_valid = s.br_valid;
        bcode    = s.bcode;
        lit      = s.lit;
        rega     = s.rega;
        pc_cur   = s.pc;
        flag_we  = s.flag_we;
        flags_in = s.flags;
        err_clr  = s.err_clr;

        taken = 0; tgt = 0; ovf_ev = 0; unf_ev = 0;
        if (s.rst) begin
            m_stk.delete();
            m_flags  = 0;
            m_target = 0;
            m_ovf    = 0;
            m_unf    = 0;
        end else begin
            eff = s.flag_we ? s.flags : m_flags;
            op  = int'(s.bcode);
            if (s.br_valid) begin
                if (op / 8 == 3) begin
                    taken = cond_holds(op % 8, eff);
                    tgt   = int'(s.lit) % PC_MOD;
                end else if (op == 32) begin
                    taken = 1;
                    tgt   = int'(s.lit) % PC_MOD;
                    m_stk.push_back((int'(s.pc) + 1) % PC_MOD);
                    if (m_stk.size() > RAS_DEPTH) begin
                        void'(m_stk.pop_front());
                        ovf_ev = 1;
                    end
                end else if (op == 33) begin
                    taken = 1;
                    tgt   = int'(s.lit) % PC_MOD;
                end else if (op == 34) begin
                    if (m_stk.size() == 0) unf_ev = 1;
                    else begin
                        taken = 1;
                        tgt   = m_stk.pop_back();
                    end
                end else if (op == 35 || (op / 16 == 2 && (op / 4) % 2 == 1)) begin
                    taken = 0;
                end else if (op / 8 == 5) begin
                    taken = 1;
                    tgt   = int'(s.rega[10:0]);
                end
            end
            if (taken) m_target = tgt[10:0];
            m_ovf = (m_ovf && !s.err_clr) || ovf_ev;
            m_unf = (m_unf && !s.err_clr) || unf_ev;
            if (s.flag_we) m_flags = s.flags;
        end
        e.taken  = taken;
        e.target = m_target;
        e.count  = m_stk.size();
        e.ovf    = m_ovf;
        e.unf    = m_unf;
        e.name   = nm;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        checks += 5;
        if (br_taken !== e.taken) begin
            errors++;
            $display("[TB] FAIL %s.taken got=%0b exp=%0b", e.name, br_taken, e.taken);
        end
        if (br_target !== e.target) begin
            errors++;
            $display("[TB] FAIL %s.target got=%03h exp=%03h", e.name, br_target, e.target);
        end
        if (int'(ras_count) != e.count || $isunknown(ras_count)) begin
            errors++;
            $display("[TB] FAIL %s.count got=%0d exp=%0d", e.name, ras_count, e.count);
        end
        if (ras_ovf !== e.ovf) begin
            errors++;
            $display("[TB] FAIL %s.ovf got=%0b exp=%0b", e.name, ras_ovf, e.ovf);
        end
        if (ras_unf !== e.unf) begin
            errors++;
            $display("[TB] FAIL %s.unf got=%0b exp=%0b", e.name, ras_unf, e.unf);
        end
    endtask

    // Monitor: the registered response to a stimulus is visible just after
    // the following rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        stim_t s;
        int r;
        rst = 1'b1; br_valid = 0; bcode = 0; lit = 0; rega = 0;
        pc_cur = 0; flag_we = 0; flags_in = 0; err_clr = 0;

        s = idle(); s.rst = 1;
        applyStimulus(s, "reset0");
        applyStimulus(s, "reset1");

        s = br(6'b011000, 'h155, 0); s.flag_we = 1; s.flags = 4'b0001;
        applyStimulus(s, "cond_z_bypass");
        applyStimulus(br(6'b011001, 'h155, 0), "cond_nz");

        s = idle(); s.flag_we = 1; s.flags = 4'b0010;
        applyStimulus(s, "flag_load");
        applyStimulus(idle(), "idle_a");
        applyStimulus(br(6'b011010, 'h020, 0), "cond_c");
        applyStimulus(br(6'b011011, 'h044, 0), "cond_nc");

        applyStimulus(br(6'b100000, 'h300, 'h100), "call");
        applyStimulus(br(6'b100010, 0, 0), "ret");

        for (int i = 0; i < 9; i++) applyStimulus(br(6'b100000, 'h400 + i, 'h010 + i), "ovf_call");
        for (int i = 0; i < 8; i++) applyStimulus(br(6'b100010, 0, 0), "ovf_ret");
        applyStimulus(br(6'b100010, 0, 0), "unf_ret");
        s = idle(); s.err_clr = 1;
        applyStimulus(s, "err_clr");

        s = br(6'b101000, 0, 0); s.rega = 32'hFFFF_F7FF;
        applyStimulus(s, "jr");
        applyStimulus(br(6'b100000, 'h123, 'h7FF), "call_wrap");
        applyStimulus(br(6'b100010, 0, 0), "ret_wrap");
        applyStimulus(br(6'b100011, 'h3AA, 0), "reserved");
        applyStimulus(br(6'b101100, 'h3AA, 0), "reserved_jr");

        applyStimulus(br(6'b100010, 0, 0), "unf_again");
        applyStimulus(br(6'b100000, 'h200, 'h050), "pre_rst_call");
        s = br(6'b100000, 'h250, 'h060); s.rst = 1;
        applyStimulus(s, "rst_midstream");
        applyStimulus(br(6'b100001, 'h0AB, 0), "after_rst_jmp");

        for (int n = 0; n < 600; n++) begin
            s          = idle();
            s.br_valid = ($urandom_range(0, 99) < 85);
            r          = $urandom_range(0, 9);
            case (r)
                0, 1, 2: s.bcode = {3'b011, 3'($urandom_range(0, 7))};
                3:       s.bcode = 6'b100000;
                4, 5:    s.bcode = 6'b100010;
                6:       s.bcode = 6'b100001;
                7:       s.bcode = {3'b101, 3'($urandom_range(0, 7))};
                8:       s.bcode = ($urandom_range(0, 1) != 0) ? 6'b100011
                                   : {2'b10, 1'($urandom_range(0, 1)), 1'b1, 2'($urandom_range(0, 3))};
                default: s.bcode = 6'($urandom_range(0, 63));
            endcase
            s.lit     = $urandom;
            s.rega    = $urandom;
            s.pc      = 11'($urandom_range(0, PC_MOD - 1));
            s.flag_we = ($urandom_range(0, 3) == 0);
            s.flags   = 4'($urandom_range(0, 15));
            s.err_clr = ($urandom_range(0, 15) == 0);
            s.rst     = ($urandom_range(0, 149) == 0);
            applyStimulus(s, "random");
        end

        applyStimulus(idle(), "drain");
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_unit_ras.md
Name: branch_unit_ras

Overview:
Registered, parametrised branch-resolution unit for the RISC core, in the decode/execute boundary.
- Latches ALU condition flags and resolves conditional, unconditional and register-indirect branches.
- Adds call/return support through an internal return-address stack (RAS).
- Produces a one-cycle-latency taken pulse and target PC for the fetch stage.

Parameters:
PC_W, 11, program-counter width in bits
DATA_W, 32, width of immediate/literal and register operands
RAS_DEPTH, 8, return-address stack entries (power of two, >=2)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
br_valid  in  1  bcode/operands valid this cycle
bcode  in  6  branch opcode
lit  in  DATA_W  literal target; lit[PC_W-1:0] used
rega  in  DATA_W  register target; rega[PC_W-1:0] used
pc_cur  in  PC_W  PC of the branch instruction
flag_we  in  1  load flag register from flags_in
flags_in  in  4  {ovf, sign, carry, zero} from ALU
err_clr  in  1  clear sticky error bits
br_taken  out  1  one-cycle pulse: redirect fetch
br_target  out  PC_W  redirect address, valid when br_taken=1
ras_count  out  clog2(RAS_DEPTH)+1  current stack occupancy
ras_ovf  out  1  sticky: push while full
ras_unf  out  1  sticky: pop while empty

Behaviour:
- Reset (async, rst=1): flag register=0, br_taken=0, br_target=0, ras_count=0, ras_ovf=0, ras_unf=0, RAS pointer=0. Reset mid-operation aborts any pending resolution; no taken pulse is emitted for a br_valid sampled in the reset cycle.
- Flag register: loads flags_in on clk when flag_we=1.
- Effective flags: flags_in when flag_we=1 in the same cycle (bypass); otherwise the flag register.
- Decode, evaluated only when br_valid=1; when br_valid=0, nothing is taken and the RAS is unchanged.
  - 011ccc conditional, target lit. ccc=0 Z=1, 1 Z=0, 2 C=1, 3 C=0, 4 S=1, 5 S=0, 6 V=1, 7 V=0.
  - 100000 CALL: taken, target lit; push (pc_cur+1) mod 2^PC_W.
  - 100001 JMP: taken, target lit.
  - 100010 RET: pop; target = popped entry.
  - 100011 and 10x1xx: reserved, not taken, no RAS action.
  - 101xxx JR: taken, target rega.
  - All other codes: not taken.
- Latency: decision registered; br_taken/br_target appear the cycle after br_valid. br_taken is high exactly one cycle per taken branch. br_target holds its last value when not taken.
- RAS: circular buffer indexed by a top pointer; ras_count saturates at RAS_DEPTH.
  - Push while full: oldest entry overwritten (pointer wraps), ras_count stays RAS_DEPTH, ras_ovf set.
  - Pop while empty: br_taken=0, br_target unchanged, ras_unf set, count stays 0.
  - Pointer wraps modulo RAS_DEPTH in both directions.
- Sticky errors: err_clr=1 clears both bits. If err_clr coincides with a new error event, the set wins.
- Back-to-back br_valid every cycle is supported. A RET immediately after a CALL returns that CALL's address (push visible next cycle).

Decomposition:
- Shared package (risc_pkg): bcode constants (BC_COND=3'b011, BC_CALL=6'b100000, BC_JMP=6'b100001, BC_RET=6'b100010, BC_JR=3'b101), flag bit indices (FLG_Z=0, FLG_C=1, FLG_S=2, FLG_V=3).
- Sub-module ras_stack (params PC_W, RAS_DEPTH): push/pop/data/count/full/empty, wrap and overwrite logic. Condition evaluation and output registers stay in the top level.

Test Plan:
- Reset/cond: rst pulse then flag_we=1 flags_in=4'b0001, same cycle br_valid bcode=6'b011000 lit=0x155 -> next cycle br_taken=1 br_target=0x155; repeat with bcode=011001 -> br_taken=0.
- Flag hold: flag_we=1 flags_in=4'b0010 (C=1), then two cycles later bcode=011010 lit=0x020 -> br_taken=1 br_target=0x020; bcode=011011 -> not taken.
- Call/return: pc_cur=0x100 CALL lit=0x300 -> taken 0x300 and ras_count=1; next cycle RET -> taken 0x101 and ras_count=0.
- Overflow: 9 CALLs with pc_cur=0x010..0x018 (RAS_DEPTH=8) -> ras_ovf=1, count=8; 8 RETs yield 0x019 down to 0x012; 9th RET -> br_taken=0, ras_unf=1.
- JR and wrap: bcode=6'b101000 rega=0xFFFF_F7FF -> br_target=0x7FF; CALL at pc_cur=0x7FF -> pushed 0x000.
- Async reset mid-stream: rst asserted between a CALL cycle and its output cycle -> br_taken stays 0, ras_count=0; err_clr clears sticky bits.
